// File: rtl/score_bcd.sv
// score_bcd: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A captured score is shifted into a 20-bit BCD accumulator over W_IN cycles. The result is
// then copied to the digit outputs in a single LOAD cycle, so the display never sees a
// partial value.
// Optional feature: define SCORE_SAT_EN to clamp inputs above 9999 and report it on ovf.
module score_bcd #(
    parameter int unsigned W_IN = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_IN-1:0] score_in,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [3:0]      dig4,
    output logic [3:0]      dig3,
    output logic [3:0]      dig2,
    output logic [3:0]      dig1,
    output logic [3:0]      dig0,
    output logic            ovf
);

    localparam logic [3:0] CntLast = 4'(W_IN - 1);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e state_q, state_d;

    logic [W_IN-1:0] sh_q;
    logic [19:0]     acc_q;
    logic [19:0]     acc_adj;
    logic [3:0]      cnt_q;
    logic [19:0]     dig_q;
    logic            done_q;

    logic            capture;
    logic            shift_en;
    logic            load_en;
    logic [W_IN-1:0] cap_val;

`ifdef SCORE_SAT_EN
    localparam logic [W_IN-1:0] SatMax = W_IN'(9999);

    logic cap_clamp;
    logic clamp_q;
    logic ovf_q;

    // Clamp oversized scores to the 4-digit window at capture time
    always_comb begin
        cap_clamp = (score_in > SatMax);
        cap_val   = cap_clamp ? SatMax : score_in;
    end

    // Remember the clamp until LOAD, then publish it alongside the digits
    always_ff @(posedge clk) begin
        if (rst) begin
            clamp_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (capture) begin
                clamp_q <= cap_clamp;
            end
            if (load_en) begin
                ovf_q <= clamp_q;
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign cap_val = score_in;
    assign ovf     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StShift;
            StShift: if (cnt_q == CntLast) state_d = StLoad;
            StLoad:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded controls; start is dropped unless idle
    always_comb begin
        busy     = (state_q != StIdle);
        capture  = (state_q == StIdle) && start;
        shift_en = (state_q == StShift);
        load_en  = (state_q == StLoad);
    end

    // Add 3 to every BCD nibble >= 5 before the shift; cannot overflow a nibble
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 5; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion datapath: capture, then shift {acc, sh} left once per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (capture) begin
            sh_q  <= cap_val;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            {acc_q, sh_q} <= {acc_adj, sh_q} << 1;
            cnt_q         <= cnt_q + 4'd1;
        end
    end

    // Result registers: digits only move on the LOAD edge, done pulses with them
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= load_en;
            if (load_en) begin
                dig_q <= acc_q;
            end
        end
    end

    assign done = done_q;
    assign dig4 = dig_q[19:16];
    assign dig3 = dig_q[15:12];
    assign dig2 = dig_q[11:8];
    assign dig1 = dig_q[7:4];
    assign dig0 = dig_q[3:0];

endmodule

// File: tb/tb_score_bcd.sv
// Directed and swept checks for score_bcd. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
module tb_score_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] score_in;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  dig4, dig3, dig2, dig1, dig0;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [19:0] digs;
    assign digs = {dig4, dig3, dig2, dig1, dig0};

    score_bcd #(.W_IN(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .score_in (score_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .dig4     (dig4),
        .dig3     (dig3),
        .dig2     (dig2),
        .dig1     (dig1),
        .dig0     (dig0),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Decimal reference, including the optional clamp
    function automatic logic [19:0] ref_bcd(input int v);
        int x;
        x = v;
`ifdef SCORE_SAT_EN
        if (x > 9999) x = 9999;
`endif
        return {4'((x / 10000) % 10), 4'((x / 1000) % 10), 4'((x / 100) % 10),
                4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic ref_ovf(input int v);
`ifdef SCORE_SAT_EN
        return (v > 9999);
`else
        return (v < 0);
`endif
    endfunction

    // Present start for exactly one edge (E0); returns 1 unit after E0
    task automatic start_conv(input int v);
        score_in = 16'(v);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        score_in = 16'hA5A5;
    endtask

    // Count edges after E0 until done is seen, bounded
    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        score_in = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, ovf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/done/ovf=%b required 000", {busy, done, ovf});
        end
        n_checks++;
        if (digs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_digits: got %h required 00000", digs);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        int cyc;
        int busy_cyc;
        cyc      = 0;
        busy_cyc = 0;
        start_conv(0);
        if (busy) busy_cyc++;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_cyc++;
            if (done) break;
        end
        n_checks++;
        if (cyc !== 17) begin
            n_fail++;
            $display("FAIL zero_latency: got %0d cycles required 17", cyc);
        end
        n_checks++;
        if (busy_cyc !== 17) begin
            n_fail++;
            $display("FAIL zero_busy_len: got %0d cycles required 17", busy_cyc);
        end
        n_checks++;
        if ({done, busy, digs} !== {1'b1, 1'b0, 20'h00000}) begin
            n_fail++;
            $display("FAIL zero_result: got done=%b busy=%b digits=%h required 1 0 00000",
                     done, busy, digs);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_pulse: got done=%b after E18 required 0", done);
        end
    endtask

    task automatic test_max_then_small();
        int  cyc;
        bit  seen;
        start_conv(65535);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || digs !== ref_bcd(65535) || ovf !== ref_ovf(65535)) begin
            n_fail++;
            $display("FAIL max_value: got seen=%b digits=%h ovf=%b required 1 %h %b",
                     seen, digs, ovf, ref_bcd(65535), ref_ovf(65535));
        end
        // back-to-back: start in the done cycle
        start_conv(1234);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc !== 17 || digs !== 20'h01234 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL after_max_1234: got seen=%b cyc=%0d digits=%h ovf=%b required 1 17 01234 0",
                     seen, cyc, digs, ovf);
        end
    endtask

    task automatic test_hold_2048();
        int          cyc;
        bit          moved;
        logic [19:0] prev;
        prev  = digs;
        moved = 1'b0;
        cyc   = 0;
        start_conv(2048);
        while (cyc < 40) begin
            if (!done && digs !== prev) moved = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        n_checks++;
        if (moved) begin
            n_fail++;
            $display("FAIL hold_during_busy: digits left %h before done", prev);
        end
        n_checks++;
        if (cyc !== 17 || digs !== 20'h02048 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL conv_2048: got cyc=%0d digits=%h ovf=%b required 17 02048 0",
                     cyc, digs, ovf);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_drop();
        int cyc;
        int n_done;
        bit seen;
        cyc    = 0;
        n_done = 0;
        start_conv(512);
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                n_done++;
                break;
            end
            if (cyc == 4) begin
                score_in = 16'd999;
                start    = 1'b1;
            end
            if (cyc == 5) start = 1'b0;
        end
        n_checks++;
        if (n_done !== 1 || cyc !== 17 || digs !== 20'h00512) begin
            n_fail++;
            $display("FAIL busy_drop: got dones=%0d cyc=%0d digits=%h required 1 17 00512",
                     n_done, cyc, digs);
        end
        // start during the done cycle is accepted
        start_conv(999);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc !== 17 || digs !== 20'h00999) begin
            n_fail++;
            $display("FAIL start_in_done: got seen=%b cyc=%0d digits=%h required 1 17 00999",
                     seen, cyc, digs);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int n_done;
        bit seen;
        n_done = 0;
        @(posedge clk);
        #1;
        start_conv(4096);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({busy, done, ovf, digs} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b digits=%h required 0 0 0 00000",
                     busy, done, ovf, digs);
        end
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d done pulses required 0", n_done);
        end
        start_conv(16);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc !== 17 || digs !== 20'h00016) begin
            n_fail++;
            $display("FAIL after_reset_16: got seen=%b cyc=%0d digits=%h required 1 17 00016",
                     seen, cyc, digs);
        end
    endtask

    task automatic test_random();
        int cyc;
        bit seen;
        int v;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0)      v = 9999;
            else if (i == 1) v = 10000;
            else if (i == 2) v = 9;
            else if (i == 3) v = 10;
            else             v = int'($urandom_range(65535, 0));
            start_conv(v);
            wait_done(cyc, seen);
            n_checks++;
            if (!seen || cyc !== 17 || digs !== ref_bcd(v) || ovf !== ref_ovf(v)) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: got seen=%b cyc=%0d digits=%h ovf=%b required 1 17 %h %b",
                             v, seen, cyc, digs, ovf, ref_bcd(v), ref_ovf(v));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max_then_small();
        test_hold_2048();
        test_busy_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
